// File: rtl/colisor_tiro.sv
// colisor_tiro: resolves one shot against a board row held in external memory.
// It requests the collision slot, reads the row, classifies the target cell,
// writes back the updated row and keeps per-board hit counts for end of game.
module colisor_tiro #(
    parameter int unsigned GRANT_WAIT    = 3,
    parameter int unsigned READ_LAT      = 2,
    parameter int unsigned NAVIO_CELULAS = 17
) (
    input  logic        clk,
    input  logic        resetGeral,
    input  logic        tiro_valido,
    input  logic        tiro_jogador,
    input  logic [4:0]  tiro_linha,
    input  logic [4:0]  tiro_coluna,
    input  logic [63:0] dataReadColisor,
    output logic        readyColisor,
    output logic        jogadorColisor,
    output logic [4:0]  colisor_addr,
    output logic [63:0] colisor_data,
    output logic        colisor_wrep1,
    output logic        colisor_wrep2,
    output logic        ocupado,
    output logic        erro_ocupado,
    output logic        resultado_valido,
    output logic        resultado_acerto,
    output logic        resultado_repetido,
    output logic [7:0]  acertos_p1,
    output logic [7:0]  acertos_p2,
    output logic        fim_jogo,
    output logic        vencedor
);

    localparam int unsigned MAXW = (GRANT_WAIT > READ_LAT) ? GRANT_WAIT : READ_LAT;
    localparam int unsigned CW   = (MAXW > 1) ? $clog2(MAXW) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_READ  = 3'd2,
        S_EVAL  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [4:0]    col_q;
    logic [63:0]   linha_reg_q;
    logic          acerto_q;
    logic          ready_q, jog_q, wrep1_q, wrep2_q, ocupado_q, valido_q;
    logic          res_acerto_q, res_rep_q, fim_q, venc_q;
    logic [4:0]    addr_q;
    logic [63:0]   data_q;
    logic [7:0]    p1_q, p2_q;

    logic [5:0]    sh_c;
    logic [1:0]    cell_c;
    logic [63:0]   data_d;
    logic [7:0]    p1_d, p2_d;

    // Target cell extraction, updated row and saturating next hit counts
    always_comb begin
        sh_c   = {col_q, 1'b0};
        cell_c = 2'(linha_reg_q >> sh_c);
        data_d = (linha_reg_q & ~(64'h3 << sh_c)) | (64'({1'b1, cell_c[0]}) << sh_c);
        p1_d   = (p1_q == 8'hFF) ? 8'hFF : p1_q + 8'd1;
        p2_d   = (p2_q == 8'hFF) ? 8'hFF : p2_q + 8'd1;
    end

    // Shot sequencing FSM with registered outputs and hit bookkeeping
    always_ff @(posedge clk or posedge resetGeral) begin
        if (resetGeral) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            col_q        <= '0;
            linha_reg_q  <= '0;
            acerto_q     <= 1'b0;
            ready_q      <= 1'b0;
            jog_q        <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            wrep1_q      <= 1'b0;
            wrep2_q      <= 1'b0;
            ocupado_q    <= 1'b0;
            valido_q     <= 1'b0;
            res_acerto_q <= 1'b0;
            res_rep_q    <= 1'b0;
            p1_q         <= '0;
            p2_q         <= '0;
            fim_q        <= 1'b0;
            venc_q       <= 1'b0;
        end else begin
            valido_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (tiro_valido && !fim_q) begin
                        jog_q     <= tiro_jogador;
                        addr_q    <= tiro_linha;
                        col_q     <= tiro_coluna;
                        cnt_q     <= '0;
                        ready_q   <= 1'b1;
                        ocupado_q <= 1'b1;
                        state_q   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (cnt_q == CW'(GRANT_WAIT - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_READ;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_READ: begin
                    if (cnt_q == CW'(READ_LAT - 1)) begin
                        cnt_q       <= '0;
                        linha_reg_q <= dataReadColisor;
                        state_q     <= S_EVAL;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_EVAL: begin
                    if (cell_c[1]) begin
                        // Already shot: report repeat and skip the write
                        acerto_q     <= 1'b0;
                        ready_q      <= 1'b0;
                        valido_q     <= 1'b1;
                        res_acerto_q <= 1'b0;
                        res_rep_q    <= 1'b1;
                        state_q      <= S_DONE;
                    end else begin
                        acerto_q <= cell_c[0];
                        data_q   <= data_d;
                        wrep1_q  <= ~jog_q;
                        wrep2_q  <= jog_q;
                        state_q  <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    wrep1_q      <= 1'b0;
                    wrep2_q      <= 1'b0;
                    ready_q      <= 1'b0;
                    valido_q     <= 1'b1;
                    res_acerto_q <= acerto_q;
                    res_rep_q    <= 1'b0;
                    state_q      <= S_DONE;
                end
                S_DONE: begin
                    ocupado_q <= 1'b0;
                    state_q   <= S_IDLE;
                    if (res_acerto_q) begin
                        if (jog_q) begin
                            p2_q <= p2_d;
                            if (p2_d == 8'(NAVIO_CELULAS)) begin
                                fim_q  <= 1'b1;
                                venc_q <= ~jog_q;
                            end
                        end else begin
                            p1_q <= p1_d;
                            if (p1_d == 8'(NAVIO_CELULAS)) begin
                                fim_q  <= 1'b1;
                                venc_q <= ~jog_q;
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Dropped-shot flag must pulse in the same cycle as the rejected strobe
    assign erro_ocupado       = tiro_valido & ((state_q != S_IDLE) | fim_q);

    assign readyColisor       = ready_q;
    assign jogadorColisor     = jog_q;
    assign colisor_addr       = addr_q;
    assign colisor_data       = data_q;
    assign colisor_wrep1      = wrep1_q;
    assign colisor_wrep2      = wrep2_q;
    assign ocupado            = ocupado_q;
    assign resultado_valido   = valido_q;
    assign resultado_acerto   = res_acerto_q;
    assign resultado_repetido = res_rep_q;
    assign acertos_p1         = p1_q;
    assign acertos_p2         = p2_q;
    assign fim_jogo           = fim_q;
    assign vencedor           = venc_q;

endmodule

// File: tb/tb_colisor_tiro.sv
// Bench for colisor_tiro: memory emulation, behavioural shot model and
// per-cycle comparison, plus directed scenarios with literal expectations.
module tb_colisor_tiro;

    localparam int G = 3;
    localparam int R = 2;
    localparam int N = 17;

    logic        clk = 1'b0;
    logic        resetGeral;
    logic        tiro_valido;
    logic        tiro_jogador;
    logic [4:0]  tiro_linha;
    logic [4:0]  tiro_coluna;
    logic [63:0] dataReadColisor;
    logic        readyColisor, jogadorColisor;
    logic [4:0]  colisor_addr;
    logic [63:0] colisor_data;
    logic        colisor_wrep1, colisor_wrep2, ocupado, erro_ocupado;
    logic        resultado_valido, resultado_acerto, resultado_repetido;
    logic [7:0]  acertos_p1, acertos_p2;
    logic        fim_jogo, vencedor;

    colisor_tiro #(.GRANT_WAIT(G), .READ_LAT(R), .NAVIO_CELULAS(N)) dut (
        .clk(clk), .resetGeral(resetGeral), .tiro_valido(tiro_valido),
        .tiro_jogador(tiro_jogador), .tiro_linha(tiro_linha), .tiro_coluna(tiro_coluna),
        .dataReadColisor(dataReadColisor), .readyColisor(readyColisor),
        .jogadorColisor(jogadorColisor), .colisor_addr(colisor_addr),
        .colisor_data(colisor_data), .colisor_wrep1(colisor_wrep1),
        .colisor_wrep2(colisor_wrep2), .ocupado(ocupado), .erro_ocupado(erro_ocupado),
        .resultado_valido(resultado_valido), .resultado_acerto(resultado_acerto),
        .resultado_repetido(resultado_repetido), .acertos_p1(acertos_p1),
        .acertos_p2(acertos_p2), .fim_jogo(fim_jogo), .vencedor(vencedor)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Board memory seen by the DUT; preloads arrive through pre_mem/load_gen
    logic [63:0] mem     [2][32];
    logic [63:0] pre_mem [2][32];
    int          load_gen = 0;
    int          seen_gen = 0;
    assign dataReadColisor = mem[jogadorColisor][colisor_addr];

    // Behavioural model: shot outcome from the cell rules, timing from the phase table
    logic        m_busy, m_rep, m_hit, m_j, m_fim, m_venc, h_ac, h_rep;
    logic [4:0]  m_r, m_c;
    logic [63:0] m_new;
    logic [1:0]  m_cell;
    int          m_cyc;
    int          m_cnt [2];

    function automatic int last_cyc(input logic rep);
        return rep ? (G + R + 2) : (G + R + 3);
    endfunction

    always @(posedge clk or posedge resetGeral) begin
        if (resetGeral) begin
            m_busy = 1'b0; m_cyc = 0; m_rep = 1'b0; m_hit = 1'b0;
            m_cnt[0] = 0; m_cnt[1] = 0; m_fim = 1'b0; m_venc = 1'b0;
            h_ac = 1'b0; h_rep = 1'b0;
        end else begin
            if (load_gen != seen_gen) begin
                mem = pre_mem;
                seen_gen = load_gen;
            end
            if (m_busy) begin
                if (m_cyc == last_cyc(m_rep)) begin
                    m_busy = 1'b0;
                    if (m_hit) begin
                        if (m_cnt[m_j] < 255) m_cnt[m_j] = m_cnt[m_j] + 1;
                        if (m_cnt[m_j] == N) begin
                            m_fim = 1'b1;
                            m_venc = ~m_j;
                        end
                    end
                end else begin
                    if (!m_rep && m_cyc == G + R + 2) mem[m_j][m_r] = m_new;
                    m_cyc = m_cyc + 1;
                    if (m_cyc == last_cyc(m_rep)) begin
                        h_ac = m_hit;
                        h_rep = m_rep;
                    end
                end
            end else if (tiro_valido && !m_fim) begin
                m_busy = 1'b1;
                m_cyc = 1;
                m_j = tiro_jogador;
                m_r = tiro_linha;
                m_c = tiro_coluna;
                m_cell = 2'(mem[m_j][m_r] >> (2 * int'(m_c)));
                m_rep = m_cell[1];
                m_hit = (m_cell == 2'b01);
                m_new = mem[m_j][m_r];
                m_new[2 * int'(m_c) +: 2] = m_hit ? 2'b11 : 2'b10;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    logic cmp_en = 1'b0;
    logic e_ready, e_valid, e_w;
    always @(negedge clk) begin
        if (cmp_en) begin
            e_ready = m_busy && (m_cyc < last_cyc(m_rep));
            e_valid = m_busy && (m_cyc == last_cyc(m_rep));
            e_w     = m_busy && !m_rep && (m_cyc == G + R + 2);
            chk("readyColisor", 64'(readyColisor), 64'(e_ready));
            chk("ocupado", 64'(ocupado), 64'(m_busy));
            chk("wrep1", 64'(colisor_wrep1), 64'(e_w && !m_j));
            chk("wrep2", 64'(colisor_wrep2), 64'(e_w && m_j));
            chk("resultado_valido", 64'(resultado_valido), 64'(e_valid));
            chk("resultado_acerto", 64'(resultado_acerto), 64'(h_ac));
            chk("resultado_repetido", 64'(resultado_repetido), 64'(h_rep));
            chk("acertos_p1", 64'(acertos_p1), 64'(m_cnt[0]));
            chk("acertos_p2", 64'(acertos_p2), 64'(m_cnt[1]));
            chk("fim_jogo", 64'(fim_jogo), 64'(m_fim));
            chk("vencedor", 64'(vencedor), 64'(m_venc));
            chk("erro_ocupado", 64'(erro_ocupado), 64'(tiro_valido && (m_busy || m_fim)));
            if (m_busy) begin
                chk("jogadorColisor", 64'(jogadorColisor), 64'(m_j));
                chk("colisor_addr", 64'(colisor_addr), 64'(m_r));
            end
            if (e_w) chk("colisor_data", colisor_data, m_new);
        end
    end

    task automatic load();
        load_gen++;
    endtask

    // Present one shot strobe; called just after a rising edge
    task automatic fire(input logic j, input logic [4:0] r, input logic [4:0] c, output logic err);
        tiro_valido = 1'b1; tiro_jogador = j; tiro_linha = r; tiro_coluna = c;
        @(negedge clk);
        err = erro_ocupado;
        @(posedge clk); #1;
        tiro_valido = 1'b0;
    endtask

    // Observe one operation starting at cycle k0 until its result strobe
    task automatic watch(input int k0, output int wcyc, output int wcount, output int vcyc,
                         output logic [63:0] wdata, output logic [4:0] waddr,
                         output logic w2, output logic ac, output logic rp);
        wcyc = -1; wcount = 0; vcyc = -1; wdata = '0; waddr = '0; w2 = 1'b0; ac = 1'b0; rp = 1'b0;
        for (int k = k0; k < k0 + 40; k++) begin
            @(negedge clk);
            if (colisor_wrep1 || colisor_wrep2) begin
                wcount++; wcyc = k; wdata = colisor_data; waddr = colisor_addr; w2 = colisor_wrep2;
            end
            if (resultado_valido) begin
                vcyc = k; ac = resultado_acerto; rp = resultado_repetido;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    int          wcyc, wcount, vcyc;
    logic [63:0] wdata;
    logic [4:0]  waddr;
    logic        w2, ac, rp, err, saw_ready;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        resetGeral = 1'b1; tiro_valido = 1'b0; tiro_jogador = 1'b0;
        tiro_linha = '0; tiro_coluna = '0;
        for (int j = 0; j < 2; j++) for (int r = 0; r < 32; r++) pre_mem[j][r] = '0;
        mem = pre_mem;
        @(posedge clk); @(posedge clk); #1;
        resetGeral = 1'b0;
        cmp_en = 1'b1;
        chk("reset_ready", 64'(readyColisor), 64'd0);
        chk("reset_counts", 64'({acertos_p1, acertos_p2}), 64'd0);

        // Miss on board 0, row 5, col 3
        load();
        fire(1'b0, 5'd5, 5'd3, err);
        watch(1, wcyc, wcount, vcyc, wdata, waddr, w2, ac, rp);
        chk("miss_wcyc", 64'(wcyc), 64'd7);
        chk("miss_wcount", 64'(wcount), 64'd1);
        chk("miss_wdata", wdata, 64'h80);
        chk("miss_waddr", 64'(waddr), 64'd5);
        chk("miss_board", 64'(w2), 64'd0);
        chk("miss_vcyc", 64'(vcyc), 64'd8);
        chk("miss_flags", 64'({ac, rp}), 64'd0);

        // Hit on board 1, row 31, col 31
        pre_mem[1][31] = 64'h4000_0000_0000_0000;
        load();
        fire(1'b1, 5'd31, 5'd31, err);
        watch(1, wcyc, wcount, vcyc, wdata, waddr, w2, ac, rp);
        chk("hit_wdata", wdata, 64'hC000_0000_0000_0000);
        chk("hit_board", 64'(w2), 64'd1);
        chk("hit_acerto", 64'(ac), 64'd1);
        chk("hit_vcyc", 64'(vcyc), 64'd8);
        chk("hit_p2", 64'(acertos_p2), 64'd1);

        // Repeat on a cell already marked hit
        pre_mem[0][7] = 64'h3 << 20;
        load();
        fire(1'b0, 5'd7, 5'd10, err);
        watch(1, wcyc, wcount, vcyc, wdata, waddr, w2, ac, rp);
        chk("rep_wcount", 64'(wcount), 64'd0);
        chk("rep_vcyc", 64'(vcyc), 64'd7);
        chk("rep_flags", 64'({ac, rp}), 64'b01);

        // Busy drop: second strobe in cycle 2 must not disturb the first shot
        pre_mem[0][12] = 64'h1 << 8;
        load();
        fire(1'b0, 5'd12, 5'd4, err);
        @(posedge clk); #1;
        tiro_valido = 1'b1; tiro_jogador = 1'b1; tiro_linha = 5'd20; tiro_coluna = 5'd9;
        @(negedge clk);
        chk("busy_erro", 64'(erro_ocupado), 64'd1);
        @(posedge clk); #1;
        tiro_valido = 1'b0;
        watch(3, wcyc, wcount, vcyc, wdata, waddr, w2, ac, rp);
        chk("busy_waddr", 64'(waddr), 64'd12);
        chk("busy_wdata", wdata, 64'h300);
        chk("busy_board", 64'(w2), 64'd0);
        chk("busy_vcyc", 64'(vcyc), 64'd8);
        chk("busy_p1", 64'(acertos_p1), 64'd1);

        // Reset during READ aborts without write or result
        fire(1'b0, 5'd3, 5'd3, err);
        repeat (3) @(posedge clk);
        #2 resetGeral = 1'b1;
        #1;
        chk("rst_ready_async", 64'(readyColisor), 64'd0);
        chk("rst_wrep_async", 64'({colisor_wrep1, colisor_wrep2}), 64'd0);
        @(posedge clk); #1;
        resetGeral = 1'b0;
        watch(1, wcyc, wcount, vcyc, wdata, waddr, w2, ac, rp);
        chk("rst_no_write", 64'(wcount), 64'd0);
        chk("rst_no_result", 64'(vcyc), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_p1_cleared", 64'(acertos_p1), 64'd0);
        fire(1'b0, 5'd3, 5'd3, err);
        watch(1, wcyc, wcount, vcyc, wdata, waddr, w2, ac, rp);
        chk("post_rst_vcyc", 64'(vcyc), 64'd8);
        chk("post_rst_wdata", wdata, 64'h80);

        // End of game: 17 hits on board 0
        for (int i = 0; i < 32; i++) pre_mem[0][i] = (i < N) ? 64'h1 : 64'h0;
        load();
        for (int i = 0; i < N; i++) begin
            fire(1'b0, 5'(i), 5'd0, err);
            watch(1, wcyc, wcount, vcyc, wdata, waddr, w2, ac, rp);
            chk("end_hit", 64'(ac), 64'd1);
        end
        chk("end_fim", 64'(fim_jogo), 64'd1);
        chk("end_vencedor", 64'(vencedor), 64'd1);
        chk("end_p1", 64'(acertos_p1), 64'd17);
        fire(1'b0, 5'd20, 5'd0, err);
        chk("end_erro", 64'(err), 64'd1);
        saw_ready = 1'b0;
        repeat (12) begin
            @(negedge clk);
            saw_ready = saw_ready | readyColisor;
        end
        chk("end_no_ready", 64'(saw_ready), 64'd0);
        @(posedge clk); #1;

        // Randomized shots over a few rows so repeats occur
        resetGeral = 1'b1;
        @(posedge clk); #1;
        resetGeral = 1'b0;
        for (int j = 0; j < 2; j++)
            for (int r = 0; r < 32; r++) pre_mem[j][r] = {$urandom, $urandom};
        load();
        for (int n = 0; n < 160; n++) begin
            if (m_fim) begin
                fire(1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom), err);
                chk("rand_end_erro", 64'(err), 64'd1);
            end else begin
                fire(1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom), err);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk); #1;
                    tiro_valido = 1'b1; tiro_jogador = 1'($urandom);
                    tiro_linha = 5'($urandom); tiro_coluna = 5'($urandom);
                    @(negedge clk);
                    @(posedge clk); #1;
                    tiro_valido = 1'b0;
                    watch(3, wcyc, wcount, vcyc, wdata, waddr, w2, ac, rp);
                end else begin
                    watch(1, wcyc, wcount, vcyc, wdata, waddr, w2, ac, rp);
                end
                chk("rand_result_seen", 64'(vcyc > 0), 64'd1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
